// File: rtl/debounce_sync.sv
// Debouncer with input synchroniser.
// A raw asynchronous level is synchronised, then accepted as the new debounced
// level only after DB_CYCLES consecutive enabled cycles at the opposite level.
// Legal configurations: SYNC_STAGES >= 2, DB_CYCLES >= 2, 2**CNT_W >= DB_CYCLES.
module debounce_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic q,
  output logic qb,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   q_d, rise_d, fall_d, busy_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; only the last stage feeds the qualifier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // State, counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_LO;
      cnt   <= '0;
      q     <= 1'b0;
      qb    <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      q     <= q_d;
      qb    <= ~q_d;
      rise  <= rise_d;
      fall  <= fall_d;
      busy  <= busy_d;
    end
  end

  // Next-state: a level change must survive DB_CYCLES enabled cycles;
  // a return to the old level always cancels, even on the final cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    q_d     = q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state)
      ST_LO: begin
        if (s && en) begin
          state_d = CHK_HI;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (en) begin
          if (cnt == CNT_MAX) begin
            state_d = ST_HI;
            cnt_d   = '0;
            q_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
      end
      ST_HI: begin
        if (!s && en) begin
          state_d = CHK_LO;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (en) begin
          if (cnt == CNT_MAX) begin
            state_d = ST_LO;
            cnt_d   = '0;
            q_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
        q_d     = 1'b0;
      end
    endcase

    busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed scenarios plus randomized traffic
// compared against a run-length reference model.
module tb_debounce_sync;

  localparam int SYNC = 2;
  localparam int DB   = 4;

  logic clk, rst, din, en;
  logic q, qb, rise, fall, busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: delayed input samples and length of the current
  // run of enabled cycles spent at the level opposite to m_q.
  logic dly[$];
  logic m_q, m_rise, m_fall;
  int   prog;

  debounce_sync #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .en  (en),
    .q   (q),
    .qb  (qb),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    dly.delete();
    for (int i = 0; i < SYNC; i++) dly.push_back(1'b0);
    m_q    = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    prog   = 0;
  endtask

  task automatic check_model();
    check("m_q",    q,    m_q);
    check("m_qb",   qb,   ~m_q);
    check("m_rise", rise, m_rise);
    check("m_fall", fall, m_fall);
    check("m_busy", busy, logic'(prog != 0));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_q"},    q,    1'b0);
    check({tag, "_qb"},   qb,   1'b1);
    check({tag, "_rise"}, rise, 1'b0);
    check({tag, "_fall"}, fall, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // One clock edge: advance the model with the pre-edge inputs, then check.
  task automatic step();
    logic d, e, r, s_used;
    d = din; e = en; r = rst;
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      s_used = dly.pop_front();
      dly.push_back(d);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s_used == m_q) begin
        prog = 0;
      end else if (e) begin
        prog++;
        if (prog == DB) begin
          m_q  = ~m_q;
          m_rise = m_q;
          m_fall = ~m_q;
          prog = 0;
        end
      end
    end
    #1;
    check_model();
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_vals(tag);
  endtask

  initial begin
    logic busy_seen, rise_seen;
    rst = 1'b1; din = 1'b0; en = 1'b1;
    model_reset();
    #2;
    din = 1'b1;
    async_reset("rst_async");

    // Reset held with din=1 for three edges.
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_vals("rst_hold");
    end
    din = 1'b0;
    rst = 1'b1;
    step(); step(); step();

    // Clean rise.
    din = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check("rise_busy", busy, logic'(i >= 3 && i <= 5));
      check("rise_q",    q,    logic'(i >= 6));
      check("rise_rise", rise, logic'(i == 6));
    end

    // Reset pulse between edges while q=1.
    #2;
    async_reset("rst_pulse");
    rst = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check("requal_q", q, logic'(i >= 6));
    end

    // Clean fall.
    din = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      check("fall_q",    q,    logic'(i < 6));
      check("fall_qb",   qb,   logic'(i >= 6));
      check("fall_fall", fall, logic'(i == 6));
      check("fall_rise", rise, 1'b0);
    end

    // Glitch: two cycles high, then low.
    busy_seen = 1'b0;
    rise_seen = 1'b0;
    din = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) din = 1'b0;
      step();
      busy_seen |= busy;
      rise_seen |= rise;
      check("glitch_q", q, 1'b0);
    end
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_no_rise",   rise_seen, 1'b0);

    // Enable stall of three cycles inside the high check.
    din = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      en = (i >= 4 && i <= 6) ? 1'b0 : 1'b1;
      step();
      check("stall_busy", busy, logic'(i >= 3 && i <= 8));
      check("stall_q",    q,    logic'(i >= 9));
      check("stall_rise", rise, logic'(i == 9));
    end
    en = 1'b1;

    // Return low, then reset mid-check at cnt=2.
    din = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("pre_mid_q", q, 1'b0);
    din = 1'b1;
    for (int i = 1; i <= 4; i++) step();
    check("mid_busy", busy, 1'b1);
    async_reset("rst_mid");
    step();
    check_reset_vals("rst_mid_hold");
    rst = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check("mid_requal_q",    q,    logic'(i >= 6));
      check("mid_requal_rise", rise, logic'(i == 6));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) din = ~din;
      en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
